alu_exec_unit: RTL and testbench



---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_iter_mul.sv | 57 +++++
 rtl/alu_exec_unit.sv | 154 +++++++++++++++
 tb/tb_alu_exec_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation-code width and encodings, and the
// execution-unit state encoding. Imported by the ALU control decoder and by
// the execution unit so the opcode producer and consumer cannot drift.
package alu_pkg;

   localparam int unsigned ALU_OP_W = 4;

   localparam logic [ALU_OP_W-1:0] OP_ADD   = 4'b0000;
   localparam logic [ALU_OP_W-1:0] OP_SUB   = 4'b0001;
   localparam logic [ALU_OP_W-1:0] OP_AND   = 4'b0010;
   localparam logic [ALU_OP_W-1:0] OP_OR    = 4'b0011;
   localparam logic [ALU_OP_W-1:0] OP_XOR   = 4'b0100;
   localparam logic [ALU_OP_W-1:0] OP_SLL   = 4'b0101;
   localparam logic [ALU_OP_W-1:0] OP_SRL   = 4'b0110;
   localparam logic [ALU_OP_W-1:0] OP_SRA   = 4'b0111;
   localparam logic [ALU_OP_W-1:0] OP_SLT   = 4'b1000;
   localparam logic [ALU_OP_W-1:0] OP_SLTU  = 4'b1001;
   localparam logic [ALU_OP_W-1:0] OP_PASSB = 4'b1010;
   localparam logic [ALU_OP_W-1:0] OP_MUL   = 4'b1100;

   // Handshake FSM states; ST_MUL is only reachable when ALU_MUL_EN is defined.
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_e;

endpackage : alu_pkg

// File: rtl/alu_iter_mul.sv
// Iterative shift-add multiplier: one multiplier bit per clock, DATA_WIDTH
// iterations, low DATA_WIDTH bits of the product. Compiled only when the
// ALU_MUL_EN macro is defined. product_o/done_o are combinational views of
// the final iteration so the caller can register the result on that edge.
`ifdef ALU_MUL_EN
module alu_iter_mul #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_i,
   input  logic                  run_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic [DATA_WIDTH-1:0] product_o,
   output logic                  done_o
);

   localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;

   logic [DATA_WIDTH-1:0] acc_q, mcand_q, mplier_q;
   logic [DATA_WIDTH-1:0] acc_d;
   logic [CNT_W-1:0]      cnt_q;

   // Accumulator value after this cycle's iteration
   always_comb begin
      acc_d = acc_q;
      if (mplier_q[0]) begin
         acc_d = acc_q + mcand_q;
      end
   end

   assign product_o = acc_d;
   assign done_o    = run_i && (cnt_q == CNT_W'(DATA_WIDTH - 1));

   // Operand latch on start, one shift-add step per running cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else if (start_i) begin
         acc_q    <= '0;
         mcand_q  <= a_i;
         mplier_q <= b_i;
         cnt_q    <= '0;
      end else if (run_i) begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + CNT_W'(1);
      end
   end

endmodule : alu_iter_mul
`endif

// File: rtl/alu_exec_unit.sv
// Execution-stage ALU with valid/ready handshake and registered result,
// zero and illegal flags. Define ALU_MUL_EN to enable the iterative multiply
// (opcode 1100); without it 1100 is treated as an unrecognised code.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [ALU_OP_W-1:0]   alu_operation_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic                  zero_o,
   output logic                  illegal_o
);

   localparam int unsigned SHAMT_W = $clog2(DATA_WIDTH);

   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic                  zero_q, zero_d;
   logic                  illegal_q, illegal_d;

   logic [SHAMT_W-1:0]    shamt_c;
   logic [DATA_WIDTH-1:0] alu_res_c;
   logic                  alu_ill_c;

   assign shamt_c = b_i[SHAMT_W-1:0];

   // Single-cycle operation result and opcode legality
   always_comb begin
      alu_res_c = '0;
      alu_ill_c = 1'b0;
      case (alu_operation_i)
         OP_ADD:   alu_res_c = a_i + b_i;
         OP_SUB:   alu_res_c = a_i - b_i;
         OP_AND:   alu_res_c = a_i & b_i;
         OP_OR:    alu_res_c = a_i | b_i;
         OP_XOR:   alu_res_c = a_i ^ b_i;
         OP_SLL:   alu_res_c = a_i << shamt_c;
         OP_SRL:   alu_res_c = a_i >> shamt_c;
         OP_SRA:   alu_res_c = DATA_WIDTH'($signed(a_i) >>> shamt_c);
         OP_SLT:   alu_res_c = DATA_WIDTH'($signed(a_i) < $signed(b_i));
         OP_SLTU:  alu_res_c = DATA_WIDTH'(a_i < b_i);
         OP_PASSB: alu_res_c = b_i;
         default:  alu_ill_c = 1'b1;
      endcase
   end

`ifdef ALU_MUL_EN
   state_e                state_q, state_d;
   logic                  mul_start_c;
   logic                  mul_run_c;
   logic                  mul_done_c;
   logic [DATA_WIDTH-1:0] mul_prod_c;

   assign ready_o   = (state_q == ST_IDLE);
   assign mul_run_c = (state_q == ST_MUL);

   alu_iter_mul #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_iter_mul (
      .clk       (clk),
      .reset     (reset),
      .start_i   (mul_start_c),
      .run_i     (mul_run_c),
      .a_i       (a_i),
      .b_i       (b_i),
      .product_o (mul_prod_c),
      .done_o    (mul_done_c)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end
`else
   assign ready_o = 1'b1;
`endif

   // Next state, multiply launch and result capture
   always_comb begin
      valid_d   = 1'b0;
      result_d  = result_q;
      zero_d    = zero_q;
      illegal_d = illegal_q;
`ifdef ALU_MUL_EN
      state_d     = state_q;
      mul_start_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (valid_i) begin
               if (alu_operation_i == OP_MUL) begin
                  mul_start_c = 1'b1;
                  state_d     = ST_MUL;
               end else begin
                  valid_d   = 1'b1;
                  result_d  = alu_res_c;
                  zero_d    = (alu_res_c == '0);
                  illegal_d = alu_ill_c;
               end
            end
         end
         ST_MUL: begin
            if (mul_done_c) begin
               valid_d   = 1'b1;
               result_d  = mul_prod_c;
               zero_d    = (mul_prod_c == '0);
               illegal_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
`else
      if (valid_i) begin
         valid_d   = 1'b1;
         result_d  = alu_res_c;
         zero_d    = (alu_res_c == '0);
         illegal_d = alu_ill_c;
      end
`endif
   end

   // Output registers; reset discards any in-flight result
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q   <= 1'b0;
         result_q  <= '0;
         zero_q    <= 1'b1;
         illegal_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         illegal_q <= illegal_d;
      end
   end

   assign valid_o   = valid_q;
   assign result_o  = result_q;
   assign zero_o    = zero_q;
   assign illegal_o = illegal_q;

endmodule : alu_exec_unit

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, multi-cycle
// corner sequences, and randomized single-cycle ops against a reference model.
// Multiply sequences are built only when ALU_MUL_EN is defined.
module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_i;
   logic        ready_o;
   logic [3:0]  alu_operation_i;
   logic [31:0] a_i, b_i;
   logic        valid_o;
   logic [31:0] result_o;
   logic        zero_o;
   logic        illegal_o;

   int n_checks = 0;
   int n_err    = 0;

   alu_exec_unit #(.DATA_WIDTH(32)) dut (
      .clk             (clk),
      .reset           (reset),
      .valid_i         (valid_i),
      .ready_o         (ready_o),
      .alu_operation_i (alu_operation_i),
      .a_i             (a_i),
      .b_i             (b_i),
      .valid_o         (valid_o),
      .result_o        (result_o),
      .zero_o          (zero_o),
      .illegal_o       (illegal_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        zero;
      logic        ill;
      string       name;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: operations from their arithmetic definitions
   function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] r,
                                   output logic ill);
      int unsigned sh;
      sh  = b % 32;
      r   = 32'd0;
      ill = 1'b0;
      case (op)
         4'd0:  r = a + b;
         4'd1:  r = a - b;
         4'd2:  r = a & b;
         4'd3:  r = a | b;
         4'd4:  r = a ^ b;
         4'd5:  r = a << sh;
         4'd6:  r = a >> sh;
         4'd7:  r = a[31] ? ~((~a) >> sh) : (a >> sh);
         4'd8:  r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
         4'd9:  r = (a < b) ? 32'd1 : 32'd0;
         4'd10: r = b;
`ifdef ALU_MUL_EN
         4'd12: r = a * b;
`endif
         default: ill = 1'b1;
      endcase
   endfunction

   task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      valid_i = v;
      alu_operation_i = op;
      a_i = a;
      b_i = b;
   endtask

   initial begin
      logic [31:0] exp_r;
      logic        exp_ill;
      logic        exp_zero;
      logic        acc;
      logic [3:0]  op;
      logic [31:0] ra, rb;
      int          n_acc, n_vo, low_cnt, cyc;
      bit          got;

      // Reset with a request pending: reset must win
      reset = 1'b1;
      drive(1'b1, 4'd0, 32'd1, 32'd2);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(ready_o), 32'd1);
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_result", result_o, 32'd0);
      chk("rst_zero", 32'(zero_o), 32'd1);
      chk("rst_illegal", 32'(illegal_o), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      drive(1'b0, 4'd0, 32'd0, 32'd0);

      vecs.push_back('{4'b0000, 32'h7FFF_FFFF, 32'd1,        32'h8000_0000, 1'b0, 1'b0, "add_ovf"});
      vecs.push_back('{4'b0001, 32'd5,         32'd5,        32'd0,         1'b1, 1'b0, "sub_zero"});
      vecs.push_back('{4'b0111, 32'h8000_0000, 32'h21,       32'hC000_0000, 1'b0, 1'b0, "sra"});
      vecs.push_back('{4'b1000, 32'hFFFF_FFFF, 32'd1,        32'd1,         1'b0, 1'b0, "slt"});
      vecs.push_back('{4'b1001, 32'hFFFF_FFFF, 32'd1,        32'd0,         1'b1, 1'b0, "sltu"});
      vecs.push_back('{4'b0010, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0, "and"});
      vecs.push_back('{4'b0011, 32'hF000_0001, 32'h0000_0010, 32'hF000_0011, 1'b0, 1'b0, "or"});
      vecs.push_back('{4'b0100, 32'hAAAA_5555, 32'hAAAA_5555, 32'd0,         1'b1, 1'b0, "xor"});
      vecs.push_back('{4'b0101, 32'h0000_0003, 32'hFFFF_FFE4, 32'h0000_0030, 1'b0, 1'b0, "sll"});
      vecs.push_back('{4'b0110, 32'h8000_0000, 32'd31,       32'd1,         1'b0, 1'b0, "srl"});
      vecs.push_back('{4'b1010, 32'h1234_5678, 32'hABCD_E000, 32'hABCD_E000, 1'b0, 1'b0, "passb"});
      vecs.push_back('{4'b0001, 32'd0,         32'd1,        32'hFFFF_FFFF, 1'b0, 1'b0, "sub_wrap"});
      vecs.push_back('{4'b1111, 32'd9,         32'd9,        32'd0,         1'b1, 1'b1, "ill_1111"});
      vecs.push_back('{4'b1011, 32'd9,         32'd9,        32'd0,         1'b1, 1'b1, "ill_1011"});
      vecs.push_back('{4'b0000, 32'd2,         32'd3,        32'd5,         1'b0, 1'b0, "add"});

      // Back-to-back table: valid_i held high, one result per cycle
      foreach (vecs[i]) begin
         @(negedge clk);
         drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
         @(posedge clk);
         #1;
         chk({vecs[i].name, "_valid"}, 32'(valid_o), 32'd1);
         chk({vecs[i].name, "_res"}, result_o, vecs[i].res);
         chk({vecs[i].name, "_zero"}, 32'(zero_o), 32'(vecs[i].zero));
         chk({vecs[i].name, "_ill"}, 32'(illegal_o), 32'(vecs[i].ill));
      end
      @(negedge clk);
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      @(posedge clk);
      #1;
      chk("idle_valid", 32'(valid_o), 32'd0);
      chk("hold_res", result_o, 32'd5);

`ifdef ALU_MUL_EN
      // MUL all-ones with an ADD held pending behind it
      @(negedge clk);
      drive(1'b1, 4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      @(posedge clk);
      @(negedge clk);
      drive(1'b1, 4'b0000, 32'd1, 32'd2);
      low_cnt = 0;
      got = 1'b0;
      for (cyc = 1; cyc <= 40 && !got; cyc++) begin
         #1;
         if (valid_o) begin
            got = 1'b1;
            chk("mul_lat", 32'(cyc), 32'd33);
            chk("mul_res", result_o, 32'd1);
            chk("mul_zero", 32'(zero_o), 32'd0);
            chk("mul_ill", 32'(illegal_o), 32'd0);
            chk("mul_ready_back", 32'(ready_o), 32'd1);
         end else if (!ready_o) begin
            low_cnt++;
         end
         if (!got) @(posedge clk);
      end
      if (!got) chk("mul_timeout", 32'd0, 32'd1);
      chk("mul_ready_low", 32'(low_cnt), 32'd32);
      @(posedge clk);
      #1;
      chk("held_add_valid", 32'(valid_o), 32'd1);
      chk("held_add_res", result_o, 32'd3);
      @(negedge clk);
      drive(1'b0, 4'd0, 32'd0, 32'd0);

      // Reset at iteration 10 of MUL 3*7
      @(negedge clk);
      drive(1'b1, 4'b1100, 32'd3, 32'd7);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      for (int k = 0; k < 9; k++) begin
         @(posedge clk);
         #1;
         chk("mul_busy_novalid", 32'(valid_o), 32'd0);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mrst_ready", 32'(ready_o), 32'd1);
      chk("mrst_valid", 32'(valid_o), 32'd0);
      chk("mrst_res", result_o, 32'd0);
      chk("mrst_zero", 32'(zero_o), 32'd1);
      chk("mrst_ill", 32'(illegal_o), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk);
         #1;
         chk("mrst_no_pulse", 32'(valid_o), 32'd0);
      end
      @(negedge clk);
      drive(1'b1, 4'b0000, 32'd2, 32'd2);
      @(posedge clk);
      #1;
      chk("post_rst_add_valid", 32'(valid_o), 32'd1);
      chk("post_rst_add_res", result_o, 32'd4);
      @(negedge clk);
      drive(1'b0, 4'd0, 32'd0, 32'd0);
`else
      // 1100 without multiply support is an unrecognised code
      @(negedge clk);
      drive(1'b1, 4'b1100, 32'd3, 32'd7);
      @(posedge clk);
      #1;
      chk("nomul_valid", 32'(valid_o), 32'd1);
      chk("nomul_res", result_o, 32'd0);
      chk("nomul_zero", 32'(zero_o), 32'd1);
      chk("nomul_ill", 32'(illegal_o), 32'd1);
      chk("nomul_ready", 32'(ready_o), 32'd1);
      @(negedge clk);
      drive(1'b0, 4'd0, 32'd0, 32'd0);
`endif

      // Randomized single-cycle operations against the model
      n_acc = 0;
      n_vo  = 0;
      exp_r = 32'd0;
      exp_ill = 1'b0;
      exp_zero = 1'b1;
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         chk("rand_ready", 32'(ready_o), 32'd1);
         acc = (c == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
         op  = 4'($urandom_range(0, 15));
`ifdef ALU_MUL_EN
         if (op == 4'b1100) op = 4'b0000;
`endif
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = ra;
            1:       rb = $urandom_range(0, 40);
            default: rb = $urandom;
         endcase
         drive(acc, op, ra, rb);
         @(posedge clk);
         #1;
         if (acc) begin
            ref_alu(op, ra, rb, exp_r, exp_ill);
            exp_zero = (exp_r == 32'd0);
            n_acc++;
         end
         if (valid_o) n_vo++;
         chk("rand_valid", 32'(valid_o), 32'(acc));
         chk("rand_res", result_o, exp_r);
         chk("rand_zero", 32'(zero_o), 32'(exp_zero));
         chk("rand_ill", 32'(illegal_o), 32'(exp_ill));
      end
      chk("valid_count", 32'(n_vo), 32'(n_acc));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule : tb_alu_exec_unit
